mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have no parameters; the datapath width SHALL be fixed at 32 bits.
REQ-002 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock, shared with the multi-cycle datapath.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to launch the operation selected by op.
REQ-006 op  input  2  operation select: 2'b00 MULT, 2'b01 MULTU, 2'b10 DIV, 2'b11 DIVU.
REQ-007 src0  input  32  rs operand (multiplicand or dividend), same operand bus as the ALU src0.
REQ-008 src1  input  32  rt operand (multiplier or divisor), same operand bus as the ALU src1.
REQ-009 hi_we  input  1  MTHI write strobe.
REQ-010 lo_we  input  1  MTLO write strobe.
REQ-011 wdata  input  32  MTHI/MTLO write data.
REQ-012 busy  output  1  high while an operation is in flight.
REQ-013 done  output  1  one-cycle pulse marking HI/LO update.
REQ-014 hi  output  32  HI register value, read by MFHI through the ALU-result path.
REQ-015 lo  output  32  LO register value, read by MFLO through the ALU-result path.

Function
REQ-016 The FSM SHALL have the states IDLE, CALC, FIX and DONE, with the transitions IDLE->CALC on start, CALC->FIX after 32 iterations, FIX->DONE, and DONE->IDLE.
REQ-017 The block SHALL capture op, src0 and src1 on the edge where start=1 in IDLE, and later changes on those inputs SHALL have no effect.
REQ-018 Multiply SHALL use radix-2 shift-add and divide SHALL use restoring shift-subtract, one iteration per CALC cycle, on operand magnitudes.
REQ-019 The FIX state SHALL negate the product when the operand signs differ, negate the quotient when the signs differ, and negate the remainder when the dividend is negative (signed ops only), then write HI/LO.
REQ-020 Multiply results SHALL be HI = product[63:32] and LO = product[31:0].
REQ-021 Divide results SHALL be LO = quotient (truncated toward zero) and HI = remainder.
REQ-022 Latency SHALL be: with the start edge as edge N, busy=1 from edge N+1 through edge N+33, hi/lo updated and done=1 at edge N+34 with busy=0, and a new start accepted from edge N+34.
REQ-023 Divide by zero (any signedness) SHALL complete with the normal latency and give LO = 32'hFFFFFFFF and HI = src0 (raw).
REQ-024 DIV 32'h80000000 / 32'hFFFFFFFF SHALL give LO = 32'h80000000 and HI = 0, with no other side effect.
REQ-025 start while busy=1 SHALL be ignored.
REQ-026 hi_we/lo_we while busy=1 SHALL be ignored, so the result wins.
REQ-027 In IDLE, hi_we/lo_we SHALL load wdata at the next edge, and both strobes together SHALL load both registers.
REQ-028 start together with hi_we/lo_we in the same IDLE cycle SHALL launch the operation and drop the write.
REQ-029 hi and lo SHALL change only on a FIX completion, an accepted write, or reset.

Reset
REQ-030 rst=1 SHALL force state=IDLE, busy=0, done=0, hi=0 and lo=0 at the next edge.
REQ-031 rst during CALC or FIX SHALL abort the operation, assert no done, and leave no partial result in hi/lo.
REQ-032 rst SHALL take priority over start and the write strobes.

Configuration
REQ-033 With MULT_DIV_DISPLAY_EN defined, the block SHALL print "HI = %x, LO = %x" on every done edge.
REQ-034 Without MULT_DIV_DISPLAY_EN, the block SHALL produce no simulation output, and cycle behaviour and results SHALL be identical in both builds.

Verification
REQ-035 MULTU with src0 = src1 = 32'hFFFFFFFF -> at edge N+34: hi = 32'hFFFFFFFE, lo = 32'h00000001, done pulse of exactly 1 cycle.
REQ-036 MULT with -3 * 7 -> hi = 32'hFFFFFFFF, lo = 32'hFFFFFFEB; DIV with -7 / 2 -> lo = 32'hFFFFFFFD, hi = 32'hFFFFFFFF.
REQ-037 DIVU with 100 / 0 -> lo = 32'hFFFFFFFF, hi = 32'h00000064; DIV with 32'h80000000 / 32'hFFFFFFFF -> lo = 32'h80000000, hi = 0.
REQ-038 MULTU 2*3 started, then start=1 with 5*5 at edge N+10 -> second start ignored, result hi = 0, lo = 6.
REQ-039 rst=1 at edge N+20 of a DIVU -> no done pulse, hi = lo = 0, busy = 0; a following lo_we with wdata = 32'h1234 -> lo = 32'h1234 at the next edge.

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle HI/LO multiply/divide unit (MULT, MULTU, DIV, DIVU)
// plus MTHI/MTLO writes.
//
// Multiply is radix-2 shift-add and divide is restoring shift-subtract. Both work
// on operand magnitudes, doing one iteration per CALC cycle for 32 cycles. FIX
// then applies the sign correction and writes HI/LO.
//
// Timing, with the start edge as edge N:
//   - busy reads 1 from edge N+1 through edge N+33.
//   - done and the new hi/lo read valid at edge N+34.
//   - A new start is accepted at edge N+34.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous, active-high reset
//   start         one-cycle launch request; sampled only while not busy
//   op[1:0]       00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src0, src1    rs / rt operands, captured on the accepted start edge
//   hi_we, lo_we  MTHI / MTLO strobes; ignored while busy or when start is taken
//   wdata         MTHI / MTLO write data
//   busy          operation in flight
//   done          one-cycle pulse when HI/LO take a result
//   hi, lo        HI / LO architectural registers
//
// Build option: define MULT_DIV_DISPLAY_EN to print "HI = %x, LO = %x" on every
// done edge. Cycle behaviour is identical with or without it.

module mult_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src0,
    input  logic [31:0] src1,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned W  = 32;
    localparam int unsigned DW = 2 * W;
    localparam int unsigned CW = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_e;

    state_e          state_q;
    logic            busy_q;
    logic            done_q;
    logic [W-1:0]    hi_q;
    logic [W-1:0]    lo_q;

    // Captured operation context
    logic            op_div_q;
    logic            a_neg_q;
    logic            b_neg_q;
    logic            div0_q;
    logic [W-1:0]    a_raw_q;
    logic [W-1:0]    b_mag_q;
    logic [CW-1:0]   cnt_q;

    // Working accumulator: {hi, lo} is the product, or {remainder, quotient/dividend}
    logic [W-1:0]    acc_hi_q;
    logic [W-1:0]    acc_lo_q;
    logic [W-1:0]    acc_hi_d;
    logic [W-1:0]    acc_lo_d;

    // Operand sign/magnitude decode at launch
    logic            src0_neg_c;
    logic            src1_neg_c;
    logic [W-1:0]    src0_mag_c;
    logic [W-1:0]    src1_mag_c;

    // Iteration datapath
    logic [W:0]      mul_sum_c;
    logic [W:0]      div_shift_c;
    logic            div_ge_c;
    logic [W-1:0]    div_sub_c;

    // Sign-fixed result
    logic [DW-1:0]   prod_neg_c;
    logic [W-1:0]    res_hi_d;
    logic [W-1:0]    res_lo_d;

    // Magnitudes; only the signed ops (op[0] == 0) look at the sign bits.
    always_comb begin
        src0_neg_c = ~op[0] & src0[W-1];
        src1_neg_c = ~op[0] & src1[W-1];
        src0_mag_c = src0_neg_c ? (~src0 + W'(1)) : src0;
        src1_mag_c = src1_neg_c ? (~src1 + W'(1)) : src1;
    end

    // One shift-add or restoring shift-subtract step.
    always_comb begin
        acc_hi_d    = acc_hi_q;
        acc_lo_d    = acc_lo_q;
        mul_sum_c   = {1'b0, acc_hi_q};
        div_shift_c = {acc_hi_q, acc_lo_q[W-1]};
        div_ge_c    = (div_shift_c >= {1'b0, b_mag_q});
        div_sub_c   = W'(div_shift_c - {1'b0, b_mag_q});

        // The multiplier sits in acc_lo and shifts out LSB-first.
        // Product bits shift in at the top.
        if (acc_lo_q[0]) begin
            mul_sum_c = {1'b0, acc_hi_q} + {1'b0, b_mag_q};
        end

        if (op_div_q) begin
            // The remainder is always below the divisor, so it fits in W bits.
            acc_hi_d = div_ge_c ? div_sub_c : div_shift_c[W-1:0];
            acc_lo_d = {acc_lo_q[W-2:0], div_ge_c};
        end else begin
            acc_hi_d = mul_sum_c[W:1];
            acc_lo_d = {mul_sum_c[0], acc_lo_q[W-1:1]};
        end
    end

    // Sign correction and the divide-by-zero override applied in FIX.
    always_comb begin
        prod_neg_c = ~{acc_hi_q, acc_lo_q} + DW'(1);
        res_hi_d   = acc_hi_q;
        res_lo_d   = acc_lo_q;

        if (!op_div_q) begin
            if (a_neg_q ^ b_neg_q) begin
                res_hi_d = prod_neg_c[DW-1:W];
                res_lo_d = prod_neg_c[W-1:0];
            end
        end else if (div0_q) begin
            res_hi_d = a_raw_q;
            res_lo_d = '1;
        end else begin
            // 0x80000000 / -1: the magnitude quotient 2^31 negates back to 0x80000000.
            if (a_neg_q ^ b_neg_q) begin
                res_lo_d = ~acc_lo_q + W'(1);
            end
            if (a_neg_q) begin
                res_hi_d = ~acc_hi_q + W'(1);
            end
        end
    end

    // Control FSM, HI/LO and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            op_div_q <= 1'b0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            div0_q   <= 1'b0;
            a_raw_q  <= '0;
            b_mag_q  <= '0;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                // DONE behaves like IDLE, so back-to-back starts cost no extra cycle.
                S_IDLE, S_DONE: begin
                    state_q <= S_IDLE;
                    if (start) begin
                        // A launch takes priority and drops any coincident MTHI/MTLO.
                        state_q  <= S_CALC;
                        busy_q   <= 1'b1;
                        op_div_q <= op[1];
                        a_neg_q  <= src0_neg_c;
                        b_neg_q  <= src1_neg_c;
                        div0_q   <= (src1 == '0);
                        a_raw_q  <= src0;
                        b_mag_q  <= src1_mag_c;
                        acc_hi_q <= '0;
                        acc_lo_q <= src0_mag_c;
                        cnt_q    <= '0;
                    end else begin
                        if (hi_we) begin
                            hi_q <= wdata;
                        end
                        if (lo_we) begin
                            lo_q <= wdata;
                        end
                    end
                end
                S_CALC: begin
                    acc_hi_q <= acc_hi_d;
                    acc_lo_q <= acc_lo_d;
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == CW'(W - 1)) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    hi_q    <= res_hi_d;
                    lo_q    <= res_lo_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_DONE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef MULT_DIV_DISPLAY_EN
    // Trace every HI/LO completion.
    always_ff @(posedge clk) begin
        if (done_q) begin
            $display("HI = %x, LO = %x", hi_q, lo_q);
        end
    end
`else
    // Quiet build: no simulation output.
`endif

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit. A scoreboard queue holds the expected {HI, LO}
// for each launched operation. The checker pops and compares it when done pulses.

module tb_mult_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src0;
    logic [31:0] src1;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int errors;
    logic [63:0] sb_q[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic        done_prev;

    mult_div_unit dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .src0  (src0),
        .src1  (src1),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Reference {HI, LO} built from the language's own arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [31:0] q;
        logic [31:0] r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (o == 2'b00) begin
            res = 64'(sa * sb);
        end else if (o == 2'b01) begin
            res = {32'b0, a} * {32'b0, b};
        end else if (b == 32'd0) begin
            res = {a, 32'hFFFF_FFFF};
        end else begin
            if (o == 2'b11) begin
                q = a / b;
                r = a % b;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = 32'd0;
            end else begin
                q = 32'(sa / sb);
                r = 32'(sa % sb);
            end
            res = {r, q};
        end
        return res;
    endfunction

    // Scoreboard checker: every done edge must match the oldest expected result.
    always @(negedge clk) begin
        if (done) begin
            check_val("done_width", 64'(done_prev), 64'd0);
            if (sb_q.size() == 0) begin
                check_val("unexp_done", 64'd1, 64'd0);
            end else begin
                logic [63:0] e;
                e = sb_q.pop_front();
                check_val("res_hi", 64'(hi), 64'(e[63:32]));
                check_val("res_lo", 64'(lo), 64'(e[31:0]));
            end
        end
        done_prev <= done;
    end

    // Called at a negedge; returns at the negedge after the write edge.
    task automatic mt_write(input logic h, input logic l, input logic [31:0] d);
        hi_we = h;
        lo_we = l;
        wdata = d;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        if (h) m_hi = d;
        if (l) m_lo = d;
        check_val("mt_hi", 64'(hi), 64'(m_hi));
        check_val("mt_lo", 64'(lo), 64'(m_lo));
    endtask

    // Called at a negedge; start is sampled on the next edge (edge N).
    // Returns at the negedge where done is seen.
    // intrude > 0 drives a new start plus MTHI/MTLO so they hit edge N+intrude.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit with_we, input int intrude);
        logic [63:0] e;
        int          j;
        bit          seen;
        e = model(o, a, b);
        sb_q.push_back(e);
        start = 1'b1;
        op    = o;
        src0  = a;
        src1  = b;
        if (with_we) begin
            hi_we = 1'b1;
            lo_we = 1'b1;
            wdata = 32'hA5A5_5A5A;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        op    = 2'($urandom);
        src0  = $urandom;
        src1  = $urandom;
        j     = 0;
        seen  = 1'b0;
        while (!seen && j < 60) begin
            @(negedge clk);
            j++;
            if (j == 1 || j == 33) begin
                check_val("busy_on", 64'(busy), 64'd1);
                check_val("hold_hi", 64'(hi), 64'(m_hi));
                check_val("hold_lo", 64'(lo), 64'(m_lo));
            end
            if (j == intrude) begin
                start = 1'b1;
                op    = 2'b01;
                src0  = 32'd5;
                src1  = 32'd5;
                hi_we = 1'b1;
                lo_we = 1'b1;
                wdata = 32'hDEAD_BEEF;
            end else begin
                start = 1'b0;
                hi_we = 1'b0;
                lo_we = 1'b0;
            end
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        check_val("latency", 64'(j), 64'd34);
        check_val("busy_off", 64'(busy), 64'd0);
        m_hi = e[63:32];
        m_lo = e[31:0];
    endtask

    initial begin
        logic [31:0] edge_v [8];
        checks    = 0;
        errors    = 0;
        m_hi      = 32'd0;
        m_lo      = 32'd0;
        done_prev = 1'b0;
        rst       = 1'b1;
        start     = 1'b0;
        op        = 2'b00;
        src0      = 32'd0;
        src1      = 32'd0;
        hi_we     = 1'b0;
        lo_we     = 1'b0;
        wdata     = 32'd0;
        edge_v[0] = 32'h0000_0000;
        edge_v[1] = 32'h0000_0001;
        edge_v[2] = 32'hFFFF_FFFF;
        edge_v[3] = 32'h8000_0000;
        edge_v[4] = 32'h7FFF_FFFF;
        edge_v[5] = 32'h0000_0007;
        edge_v[6] = 32'hFFFF_FFF9;
        edge_v[7] = 32'h1234_5678;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_hi", 64'(hi), 64'd0);
        check_val("rst_lo", 64'(lo), 64'd0);
        rst = 1'b0;

        // MTHI / MTLO alone and together
        mt_write(1'b1, 1'b0, 32'h1111_2222);
        mt_write(1'b0, 1'b1, 32'h3333_4444);
        mt_write(1'b1, 1'b1, 32'h5555_6666);

        // Directed vectors, back-to-back so each start lands at edge N+34
        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
        do_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, 0);
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
        do_op(2'b11, 32'd100, 32'd0, 1'b0, 0);
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
        do_op(2'b10, 32'hFFFF_FF00, 32'd0, 1'b0, 0);
        do_op(2'b01, 32'd2, 32'd3, 1'b0, 10);
        do_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 0);
        do_op(2'b11, 32'hFFFF_FFFF, 32'd1, 1'b0, 0);
        do_op(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0, 0);

        // Random mix of edge operands and random values
        for (int i = 0; i < 12; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = (i % 2 == 0) ? edge_v[$urandom_range(0, 7)] : $urandom;
            b = (i % 3 == 0) ? edge_v[$urandom_range(0, 7)] : $urandom;
            do_op(2'($urandom), a, b, 1'($urandom), 0);
        end

        // Reset at edge N+20 of a DIVU, with start and MTHI also asserted
        start = 1'b1;
        op    = 2'b11;
        src0  = 32'd1000;
        src1  = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            if (j == 20) begin
                rst   = 1'b1;
                start = 1'b1;
                hi_we = 1'b1;
                wdata = 32'hCAFE_F00D;
            end
        end
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        hi_we = 1'b0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        check_val("abort_busy", 64'(busy), 64'd0);
        check_val("abort_done", 64'(done), 64'd0);
        check_val("abort_hi", 64'(hi), 64'd0);
        check_val("abort_lo", 64'(lo), 64'd0);
        repeat (40) @(negedge clk);
        check_val("abort_quiet_hi", 64'(hi), 64'd0);
        mt_write(1'b0, 1'b1, 32'h0000_1234);

        repeat (3) @(negedge clk);
        check_val("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

endmodule
